wide_alu_result_serializer: RTL and testbench
=============================================

// Module: wide_alu_result_serializer
// PURPOSE
//   Downstream stage of the wide ALU. Captures each completed 2*ALU_WIDTH-bit
//   result on a one-cycle done pulse and streams it out as OUT_WIDTH-bit words
//   over a valid/ready interface, least-significant word first, with a last
//   flag on the final word. A sticky overflow flag records any results that
//   arrive while a stream is still draining; those results are dropped.
// PARAMETERS
//   ALU_WIDTH   256  operand width of the ALU; the result width RES_W is 2*ALU_WIDTH
//   OUT_WIDTH   32   stream word width; RES_W % OUT_WIDTH != 0 is an elaboration error
//   (localparam) NUM_WORDS = RES_W/OUT_WIDTH (16 by default);
//                IDX_W = $clog2(NUM_WORDS), with a minimum of 1
// PORTS
//   clk_i          in   1          clock
//   rst_ni         in   1          asynchronous active-low reset
//   res_valid_i    in   1          one-cycle pulse: res_i holds a finished result
//   res_i          in   RES_W      ALU result; only sampled while res_valid_i=1
//   clear_ovf_i    in   1          synchronous clear of overflow_o
//   data_o         out  OUT_WIDTH  current stream word
//   valid_o        out  1          data_o/idx_o/last_o are valid
//   ready_i        in   1          consumer accepts the word (handshake = valid_o & ready_i)
//   last_o         out  1          current word is word NUM_WORDS-1
//   idx_o          out  IDX_W      index of the current word, 0 = least-significant word
//   busy_o         out  1          a result is held (equals valid_o)
//   overflow_o     out  1          sticky: at least one result has been dropped
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE; valid_o, last_o, busy_o and
//     overflow_o are 0; idx_o=0; data_o=0; the shadow register is cleared.
//   - FSM has two states, IDLE and STREAM.
//     IDLE, res_valid_i=1: res_i goes into the shadow register, idx=0, next state
//     STREAM. valid_o rises the cycle after the pulse (latency 1).
//     STREAM: data_o = shadow[idx*OUT_WIDTH +: OUT_WIDTH]. On a handshake idx
//     increments. A handshake with last_o=1 returns the FSM to IDLE.
//   - Stability: while valid_o=1 and ready_i=0, data_o, idx_o and last_o hold.
//     valid_o never drops without a handshake.
//   - Throughput: one word per cycle while ready_i=1. A full result takes
//     NUM_WORDS handshakes.
//   - res_valid_i in the same cycle as the last_o handshake: the result is
//     accepted, idx goes back to 0, and valid_o stays 1 with no bubble.
//     overflow_o is unchanged.
//   - res_valid_i in STREAM with no last_o handshake that cycle: the result is
//     dropped and overflow_o is set. The current stream continues unaffected.
//   - overflow_o set and clear_ovf_i in the same cycle: set wins.
//     Otherwise clear_ovf_i drives it to 0 on the next edge.
//   - res_i is ignored when res_valid_i=0. A ready_i with valid_o=0 has no effect.
//   - Reset mid-stream: the stream is abandoned. Outputs return to reset values
//     immediately, and there is no partial replay after release.
// TESTING
//   1 Single result: res_i=512'h0F..0F00 (word k = 32'h0000_0F00 + k), ready_i=1
//     -> valid_o rises 1 cycle after the pulse; 16 back-to-back words
//     32'h0F00..32'h0F0F, idx 0..15; last_o only at idx 15; then IDLE.
//   2 Backpressure: ready_i toggled 1,0,0,1,... -> no word lost or repeated;
//     data_o/idx_o stable during every stall; last_o still only on word 15.
//   3 Overflow: a second pulse while idx=5 -> dropped; overflow_o=1; words 6..15
//     come from the first result; clear_ovf_i=1 -> overflow_o=0 next cycle.
//   4 Back-to-back: a new pulse in the same cycle as the word-15 handshake
//     -> next cycle valid_o=1, idx_o=0, data_o = new word 0; overflow_o stays 0.
//   5 Simultaneous set/clear: drop event with clear_ovf_i=1 -> overflow_o=1.
//   6 Reset at idx=7 under ready_i=0 -> valid_o=0, idx_o=0 and overflow_o=0
//     at once; after release the first pulse streams from idx 0.

Source files
------------

// File: rtl/wide_alu_result_serializer_if.sv
// Result-capture and word-stream signals of the wide ALU result serializer.
// The serializer connects through the master modport; the ALU/consumer side uses slave.
interface wide_alu_result_serializer_if #(
    parameter int ALU_WIDTH = 256,
    parameter int OUT_WIDTH = 32
);
    localparam int RES_W     = 2 * ALU_WIDTH;
    localparam int NUM_WORDS = RES_W / OUT_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic                 res_valid_i;
    logic [RES_W-1:0]     res_i;
    logic                 clear_ovf_i;
    logic [OUT_WIDTH-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 last_o;
    logic [IDX_W-1:0]     idx_o;
    logic                 busy_o;
    logic                 overflow_o;

    modport master (
        input  res_valid_i, res_i, clear_ovf_i, ready_i,
        output data_o, valid_o, last_o, idx_o, busy_o, overflow_o
    );

    modport slave (
        output res_valid_i, res_i, clear_ovf_i, ready_i,
        input  data_o, valid_o, last_o, idx_o, busy_o, overflow_o
    );
endinterface

// File: rtl/wide_alu_result_serializer.sv
// Captures a 2*ALU_WIDTH-bit ALU result on a done pulse and streams it LSW first as
// OUT_WIDTH-bit words over valid/ready; results arriving mid-stream are dropped and flagged.
module wide_alu_result_serializer #(
    parameter int ALU_WIDTH = 256,
    parameter int OUT_WIDTH = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    wide_alu_result_serializer_if.master bus
);
    localparam int RES_W     = 2 * ALU_WIDTH;
    localparam int NUM_WORDS = RES_W / OUT_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    if (RES_W % OUT_WIDTH != 0) begin : g_width_check
        $error("RES_W must be a multiple of OUT_WIDTH");
    end

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                                state_q, state_d;
    logic [NUM_WORDS-1:0][OUT_WIDTH-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic                                  last_q, last_d;
    logic [OUT_WIDTH-1:0]                  data_q, data_d;
    logic                                  ovf_q, ovf_d;

    logic hs, last_hs, drop;

    assign hs      = (state_q == STREAM) && bus.ready_i;
    assign last_hs = hs && last_q;
    // A pulse coinciding with the final handshake is a clean hand-over, not a drop.
    assign drop    = (state_q == STREAM) && bus.res_valid_i && !last_hs;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.res_valid_i) begin
                    shadow_d = bus.res_i;
                    idx_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (last_hs) begin
                    idx_d = '0;
                    if (bus.res_valid_i) shadow_d = bus.res_i;
                    else                 state_d  = IDLE;
                end else if (hs) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (drop)                 ovf_d = 1'b1;
        else if (bus.clear_ovf_i) ovf_d = 1'b0;

        // Output word and last flag are precomputed so they come straight from flops.
        last_d = (state_d == STREAM) && (idx_d == LAST_IDX);
        data_d = (state_d == STREAM) ? shadow_d[idx_d] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the shadow register is reset too, so an abandoned result can never reappear.
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.valid_o    = (state_q == STREAM);
    assign bus.busy_o     = (state_q == STREAM);
    assign bus.data_o     = data_q;
    assign bus.idx_o      = idx_q;
    assign bus.last_o     = last_q;
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_wide_alu_result_serializer.sv
// Directed plus random stimulus for wide_alu_result_serializer, compared every cycle
// against a word-position reference model of the stream.
module tb_wide_alu_result_serializer;
    localparam int ALU_WIDTH = 256;
    localparam int OUT_WIDTH = 32;
    localparam int RES_W     = 2 * ALU_WIDTH;
    localparam int NUM_WORDS = RES_W / OUT_WIDTH;

    logic clk;
    logic rst_n;

    wide_alu_result_serializer_if #(.ALU_WIDTH(ALU_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    wide_alu_result_serializer #(.ALU_WIDTH(ALU_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the held result, which word is on the bus, and the sticky flag.
    logic             m_busy;
    logic [RES_W-1:0] m_res;
    int               m_pos;
    logic             m_ovf;

    task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $error("FAIL %s bound expired", tag);
    endtask

    function automatic logic [RES_W-1:0] rand_res();
        logic [RES_W-1:0] r;
        for (int k = 0; k < NUM_WORDS; k++) r[k*OUT_WIDTH +: OUT_WIDTH] = $urandom;
        return r;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] word_of(input logic [RES_W-1:0] r, input int k);
        return r[k*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_res  = '0;
        m_pos  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic chk_all();
        chk("valid", RES_W'(bus.valid_o), RES_W'(m_busy));
        chk("busy", RES_W'(bus.busy_o), RES_W'(m_busy));
        chk("overflow", RES_W'(bus.overflow_o), RES_W'(m_ovf));
        if (m_busy) begin
            chk("data", RES_W'(bus.data_o), RES_W'(word_of(m_res, m_pos)));
            chk("idx", RES_W'(bus.idx_o), RES_W'(m_pos));
            chk("last", RES_W'(bus.last_o), RES_W'(m_pos == NUM_WORDS - 1));
        end
    endtask

    // One clock: predict from the inputs now on the bus, step, compare, then drop the pulses.
    task automatic tick();
        logic             n_busy;
        logic [RES_W-1:0] n_res;
        int               n_pos;
        logic             done_word, dropped;
        n_busy    = m_busy;
        n_res     = m_res;
        n_pos     = m_pos;
        done_word = m_busy && bus.ready_i && (m_pos == NUM_WORDS - 1);
        dropped   = m_busy && bus.res_valid_i && !done_word;
        if (!m_busy && bus.res_valid_i) begin
            n_busy = 1'b1; n_res = bus.res_i; n_pos = 0;
        end else if (done_word) begin
            n_pos = 0;
            if (bus.res_valid_i) n_res = bus.res_i;
            else n_busy = 1'b0;
        end else if (m_busy && bus.ready_i) begin
            n_pos = m_pos + 1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (bus.clear_ovf_i) m_ovf = 1'b0;
        m_busy = n_busy;
        m_res  = n_res;
        m_pos  = n_pos;
        @(posedge clk);
        #1;
        chk_all();
        bus.res_valid_i = 1'b0;
        bus.clear_ovf_i = 1'b0;
        bus.res_i       = rand_res();
    endtask

    task automatic pulse(input logic [RES_W-1:0] r);
        bus.res_valid_i = 1'b1;
        bus.res_i       = r;
    endtask

    task automatic run_to_pos(input int p);
        int n = 0;
        bus.ready_i = 1'b1;
        while (!(m_busy && m_pos == p) && n < 200) begin
            tick();
            n++;
        end
        if (!(m_busy && m_pos == p)) fail_now("run_to_pos");
    endtask

    task automatic drain();
        int n = 0;
        bus.ready_i = 1'b1;
        while (m_busy && n < 200) begin
            tick();
            n++;
        end
        if (m_busy) fail_now("drain");
    endtask

    logic [RES_W-1:0] res_a, res_b, res_c;
    int               hs_count, last_count;

    initial begin
        bus.res_valid_i = 1'b0;
        bus.res_i       = '0;
        bus.clear_ovf_i = 1'b0;
        bus.ready_i     = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("rst_valid", RES_W'(bus.valid_o), '0);
        chk("rst_idx", RES_W'(bus.idx_o), '0);
        chk("rst_data", RES_W'(bus.data_o), '0);
        chk("rst_last", RES_W'(bus.last_o), '0);
        chk("rst_ovf", RES_W'(bus.overflow_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single result, words 0x0F00+k, consumer always ready.
        for (int k = 0; k < NUM_WORDS; k++) res_a[k*OUT_WIDTH +: OUT_WIDTH] = 32'h0000_0F00 + k;
        bus.ready_i = 1'b1;
        pulse(res_a);
        tick();
        chk("t1_latency_valid", RES_W'(bus.valid_o), RES_W'(1));
        chk("t1_word0", RES_W'(bus.data_o), RES_W'(32'h0F00));
        hs_count   = 0;
        last_count = 0;
        for (int n = 0; n < 40 && bus.valid_o; n++) begin
            if (bus.ready_i) begin
                hs_count++;
                if (bus.last_o) last_count++;
            end
            tick();
        end
        chk("t1_handshakes", RES_W'(hs_count), RES_W'(NUM_WORDS));
        chk("t1_last_count", RES_W'(last_count), RES_W'(1));
        chk("t1_idle", RES_W'(bus.valid_o), '0);

        // 2: backpressure pattern 1,0,0,1 repeating.
        pulse(rand_res());
        tick();
        for (int n = 0; n < 80 && m_busy; n++) begin
            bus.ready_i = (n % 4 == 0) || (n % 4 == 3);
            tick();
        end
        drain();

        // 3: a second pulse at idx 5 is dropped, first result keeps streaming.
        res_a = rand_res();
        pulse(res_a);
        tick();
        run_to_pos(5);
        pulse(rand_res());
        tick();
        chk("t3_ovf_set", RES_W'(bus.overflow_o), RES_W'(1));
        chk("t3_word6_first", RES_W'(bus.data_o), RES_W'(word_of(res_a, 6)));
        drain();
        bus.clear_ovf_i = 1'b1;
        tick();
        chk("t3_ovf_clear", RES_W'(bus.overflow_o), '0);

        // 4: new pulse together with the word-15 handshake, no bubble.
        res_a = rand_res();
        res_b = rand_res();
        pulse(res_a);
        tick();
        run_to_pos(NUM_WORDS - 1);
        pulse(res_b);
        tick();
        chk("t4_valid", RES_W'(bus.valid_o), RES_W'(1));
        chk("t4_idx", RES_W'(bus.idx_o), '0);
        chk("t4_data", RES_W'(bus.data_o), RES_W'(word_of(res_b, 0)));
        chk("t4_ovf", RES_W'(bus.overflow_o), '0);
        drain();

        // 5: drop and clear in the same cycle, set wins.
        pulse(rand_res());
        tick();
        run_to_pos(3);
        pulse(rand_res());
        bus.clear_ovf_i = 1'b1;
        tick();
        chk("t5_set_wins", RES_W'(bus.overflow_o), RES_W'(1));
        bus.clear_ovf_i = 1'b1;
        tick();
        chk("t5_cleared", RES_W'(bus.overflow_o), '0);
        drain();

        // 6: reset at idx 7 under stall, with overflow set beforehand.
        pulse(rand_res());
        tick();
        run_to_pos(2);
        pulse(rand_res());
        tick();
        run_to_pos(7);
        bus.ready_i = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", RES_W'(bus.valid_o), '0);
        chk("t6_idx", RES_W'(bus.idx_o), '0);
        chk("t6_ovf", RES_W'(bus.overflow_o), '0);
        chk("t6_last", RES_W'(bus.last_o), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        res_c = rand_res();
        pulse(res_c);
        tick();
        chk("t6_restart_idx", RES_W'(bus.idx_o), '0);
        chk("t6_restart_data", RES_W'(bus.data_o), RES_W'(word_of(res_c, 0)));
        drain();

        // Random traffic: sparse pulses, bursty ready, occasional clears.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(11) == 0) pulse(rand_res());
            bus.ready_i     = ($urandom_range(9) < 7);
            bus.clear_ovf_i = ($urandom_range(19) == 0);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
